// File: rtl/tx_block.sv
// UART-style transmitter: one-byte holding register feeding an LSB-first start/data/stop shifter.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tx_block #(
    parameter int BIT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(BIT_PERIOD - 2);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_bit;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    hold_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic          bit_end;
    logic          load_now;

    // tx_ready doubles as the holding-register-empty flag
    assign bit_end  = (clk_cnt == CNT_LAST);
    assign load_now = !tx_ready && ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            hold_reg   <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            clk_cnt    <= '0;
            tx_ready   <= 1'b1;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= (state == STOP) && (clk_cnt == CNT_PRE);

            if (tx_valid && tx_ready) begin
                hold_reg <= tx_data;
                tx_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    clk_cnt    <= '0;
                    serial_out <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        state      <= DATA;
                        bit_idx    <= '0;
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_bit;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the IDLE/STOP exits so a pending byte starts with no idle gap
            if (load_now) begin
                state      <= START;
                shift_reg  <= hold_reg;
                tx_ready   <= 1'b1;
                serial_out <= 1'b0;
                tx_busy    <= 1'b1;
                clk_cnt    <= '0;
`ifdef TX_PARITY_EN
                parity_bit <= ^hold_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block: driver pushes expected bytes and frame start cycles,
// a line monitor decodes serial_out every clock and pops/compares against them.
module tb_tx_block;

    localparam int BP = 10;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BP;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    tx_block #(.BIT_PERIOD(BP)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serial_out(serial_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_start_q[$];
    int last_start = -100000;
    int frames_seen = 0;

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line monitor
    logic       mon_active = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    int         mon_pos = 0;
    int         mon_es = 0;
    logic [2:0] exp_vec;

    always @(negedge clk) begin
        if (n_rst !== 1'b1) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (serial_out === 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d with no byte expected", cyc);
                    end else begin
                        mon_byte = exp_q.pop_front();
                        mon_es   = exp_start_q.pop_front();
                        if (cyc != mon_es) begin
                            errors++;
                            $display("FAIL frame_start: byte %h started at cycle %0d, expected %0d", mon_byte, cyc, mon_es);
                        end
                        mon_active = 1'b1;
                        mon_pos    = 0;
                    end
                end else begin
                    checks++;
                    if ({serial_out, tx_busy, tx_done} !== 3'b100) begin
                        errors++;
                        $display("FAIL idle_line: {serial_out,tx_busy,tx_done}=%b expected 100 at cycle %0d",
                                 {serial_out, tx_busy, tx_done}, cyc);
                    end
                end
            end
            if (mon_active) begin
                exp_vec = {exp_bit(mon_byte, mon_pos / BP), 1'b1, (mon_pos == FRAME - 1)};
                checks++;
                if ({serial_out, tx_busy, tx_done} !== exp_vec) begin
                    errors++;
                    $display("FAIL frame_bit: byte %h pos %0d {serial_out,tx_busy,tx_done}=%b expected %b",
                             mon_byte, mon_pos, {serial_out, tx_busy, tx_done}, exp_vec);
                end
                mon_pos++;
                if (mon_pos == FRAME) begin
                    mon_active = 1'b0;
                    frames_seen++;
                end
            end
        end
    end

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {serial_out,tx_ready,tx_busy,tx_done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns the edge index at which the byte is taken.
    task automatic send(input logic [7:0] b, output int acc_edge);
        int es;
        acc_edge = -1;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (tx_ready === 1'b1) begin
                acc_edge = cyc + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc_edge < 0) begin
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted, tx_ready=%b", b, tx_ready);
            tx_valid = 1'b0;
        end else begin
            es = (acc_edge + 1 > last_start + FRAME) ? acc_edge + 1 : last_start + FRAME;
            last_start = es;
            exp_q.push_back(b);
            exp_start_q.push_back(es);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 4 * FRAME && frames_seen < n; k++) @(posedge clk);
        #1;
        checks++;
        if (frames_seen < n) begin
            errors++;
            $display("FAIL frame_timeout: frames seen %0d expected %0d", frames_seen, n);
        end
    endtask

    int a1, a2, a3, start1, nf;

    initial begin
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk4("reset_state", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);
        n_rst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk4("idle_50", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);

        // Single byte; busy must be low right after the frame's final clock
        send(8'hD5, a1);
        wait_frames(1);
        chk_int("single_frame_end", cyc, a1 + 1 + FRAME);
        chk4("after_single", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);

        // Back-to-back plus backpressure on a third byte
        nf = frames_seen;
        send(8'hD5, a1);
        send(8'h27, a2);
        chk_int("accept_second", a2, a1 + 2);
        chk4("both_in_flight", {serial_out, tx_ready, tx_busy, tx_done}, {serial_out, 3'b010});
        tx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tx_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        send(8'h13, a3);
        chk_int("accept_third", a3, a1 + 1 + FRAME + 1);
        wait_frames(nf + 3);
        chk4("after_burst", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);

        nf = frames_seen;
        send(8'h6A, a1);
        wait_frames(nf + 1);

        // Reset during data bit 3 with a second byte pending
        send(8'hD5, a1);
        send(8'h27, a2);
        start1 = a1 + 1;
        while (cyc < start1 + 44) begin
            @(posedge clk);
            #1;
        end
        n_rst = 1'b0;
        exp_q.delete();
        exp_start_q.delete();
        last_start = -100000;
        @(posedge clk);
        #1;
        chk4("mid_frame_reset", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);
        n_rst = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        chk4("after_reset_quiet", {serial_out, tx_ready, tx_busy, tx_done}, 4'b1100);

        nf = frames_seen;
        send(8'h13, a1);
        wait_frames(nf + 1);

        chk_int("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
